// File: rtl/tri_sum_pkg.sv
// Shared definitions for the triangular-sum FSM pair (forward sum and inverse).
// Holds state encoding, LED patterns and default widths.
package tri_sum_pkg;

   localparam int W_SUM_DEF = 7;
   localparam int W_N_DEF   = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CALC = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [9:0] LED_IDLE      = 10'h000;
   localparam logic [9:0] LED_LOAD      = 10'h001;
   localparam logic [9:0] LED_CALC      = 10'h003;
   localparam logic [9:0] LED_DONE      = 10'h007;
   localparam int         LED_EXACT_BIT = 9;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tri_sum_inverse_if.sv
// Request/result bundle between the board harness and tri_sum_inverse.
interface tri_sum_inverse_if #(
   parameter int W_SUM = 7,
   parameter int W_N   = 4
);
   logic             start;
   logic [W_SUM-1:0] target;
   logic [W_N-1:0]   n_out;
   logic [W_SUM-1:0] rem_out;
   logic             exact;
   logic             busy;
   logic             done;
   logic [9:0]       led_out;

   modport master (
      output start, target,
      input  n_out, rem_out, exact, busy, done, led_out
   );

   modport slave (
      input  start, target,
      output n_out, rem_out, exact, busy, done, led_out
   );
endinterface

// File: rtl/rise_edge_detect.sv
// Single-cycle pulse on a 0->1 transition of an already synchronised level.
module rise_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) in_q <= 1'b0;
      else     in_q <= in;
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/tri_sum_inverse.sv
// Finds the largest n with 1+2+...+n <= target by subtracting k = 1, 2, 3, ...
// one step per clock; reports n, the remainder and whether the sum was exact.
module tri_sum_inverse
   import tri_sum_pkg::*;
#(
   parameter int W_SUM = W_SUM_DEF,
   parameter int W_N   = W_N_DEF
) (
   input  logic              clk,
   input  logic              rst,
   tri_sum_inverse_if.slave  bus
);

   localparam int CW = max_int(W_SUM, W_N + 1);

   state_t           state, state_nx;
   logic             start_rise;
   logic [W_SUM-1:0] acc;
   logic [W_N:0]     k;
   logic [CW-1:0]    acc_cmp, k_cmp;
   logic             fits;
   logic             finish;

   logic [W_N-1:0]   n_q;
   logic [W_SUM-1:0] rem_q;
   logic             exact_q, exact_nx;
   logic             busy_q, busy_nx;
   logic             done_q;
   logic [9:0]       led_q, led_nx;

   rise_edge_detect u_start_edge (
      .clk   (clk),
      .rst   (rst),
      .in    (bus.start),
      .pulse (start_rise)
   );

   assign acc_cmp = CW'(acc);
   assign k_cmp   = CW'(k);
   assign fits    = (acc_cmp >= k_cmp);
   assign finish  = (state == ST_CALC) && !fits;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (start_rise) state_nx = ST_LOAD;
         ST_LOAD: state_nx = ST_CALC;
         ST_CALC: if (!fits) state_nx = ST_DONE;
         ST_DONE: if (start_rise) state_nx = ST_LOAD;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Busy and LEDs are decoded from the next state so the registered copies line up with state.
   always_comb begin
      busy_nx  = 1'b0;
      led_nx   = LED_IDLE;
      exact_nx = finish ? (acc == '0) : exact_q;
      case (state_nx)
         ST_LOAD: begin
            busy_nx = 1'b1;
            led_nx  = LED_LOAD;
         end
         ST_CALC: begin
            busy_nx = 1'b1;
            led_nx  = LED_CALC;
         end
         ST_DONE: begin
            led_nx                = LED_DONE;
            led_nx[LED_EXACT_BIT] = exact_nx;
         end
         default: led_nx = LED_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         k       <= '0;
         n_q     <= '0;
         rem_q   <= '0;
         exact_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         led_q   <= '0;
      end else begin
         busy_q  <= busy_nx;
         led_q   <= led_nx;
         done_q  <= finish;
         exact_q <= exact_nx;
         case (state)
            ST_LOAD: begin
               acc <= bus.target;
               k   <= {{W_N{1'b0}}, 1'b1};
            end
            ST_CALC: begin
               if (fits) begin
                  acc <= W_SUM'(acc_cmp - k_cmp);
                  k   <= k + 1'b1;
               end else begin
                  n_q   <= W_N'(k - 1'b1);
                  rem_q <= acc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.n_out   = n_q;
   assign bus.rem_out = rem_q;
   assign bus.exact   = exact_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.led_out = led_q;

endmodule

// File: tb/tb_tri_sum_inverse.sv
// Directed bench for tri_sum_inverse: hand-computed vectors, mid-run disturbances,
// reset during CALC and a full sweep of target values against a reference model.
module tb_tri_sum_inverse;
   import tri_sum_pkg::*;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   int          done_at;
   int          done_cnt;
   logic        busy_at1;
   logic [9:0]  led_at1;
   int          ref_n;
   int          ref_rem;

   tri_sum_inverse_if #(.W_SUM(W_SUM_DEF), .W_N(W_N_DEF)) bus ();

   tri_sum_inverse #(.W_SUM(W_SUM_DEF), .W_N(W_N_DEF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Produces one start edge E; cycle c of the watch loop is sampled just after edge E+c.
   task automatic apply_stimulus(input logic [6:0] s, input logic hold, input int budget,
                                 output int d_at, output int d_cnt,
                                 output logic b1, output logic [9:0] l1);
      bus.start  = 1'b0;
      tick();
      bus.target = s;
      bus.start  = 1'b1;
      tick();
      if (!hold) bus.start = 1'b0;
      d_at  = -1;
      d_cnt = 0;
      b1    = 1'b0;
      l1    = '0;
      for (int c = 1; c <= budget; c++) begin
         tick();
         if (c == 1) begin
            b1 = bus.busy;
            l1 = bus.led_out;
         end
         if (bus.done === 1'b1) begin
            if (d_at < 0) d_at = c;
            d_cnt++;
         end
      end
      bus.start = 1'b0;
   endtask

   function automatic int model_n(input int s);
      int n = 0;
      while (((n + 1) * (n + 2)) / 2 <= s) n++;
      return n;
   endfunction

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.target = '0;
      tick();
      tick();
      check_output("reset_n",     32'(bus.n_out),   32'd0);
      check_output("reset_rem",   32'(bus.rem_out), 32'd0);
      check_output("reset_exact", 32'(bus.exact),   32'd0);
      check_output("reset_busy",  32'(bus.busy),    32'd0);
      check_output("reset_done",  32'(bus.done),    32'd0);
      check_output("reset_led",   32'(bus.led_out), 32'h000);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // S=10: 1+2+3+4 = 10 exactly
      apply_stimulus(7'd10, 1'b0, 22, done_at, done_cnt, busy_at1, led_at1);
      check_output("s10_done_at",  32'(done_at),      32'd6);
      check_output("s10_done_cnt", 32'(done_cnt),     32'd1);
      check_output("s10_busy_e1",  32'(busy_at1),     32'd1);
      check_output("s10_led_e1",   32'(led_at1),      32'h003);
      check_output("s10_n",        32'(bus.n_out),    32'd4);
      check_output("s10_rem",      32'(bus.rem_out),  32'd0);
      check_output("s10_exact",    32'(bus.exact),    32'd1);
      check_output("s10_led",      32'(bus.led_out),  32'h207);
      check_output("s10_busy_end", 32'(bus.busy),     32'd0);

      apply_stimulus(7'd0, 1'b0, 22, done_at, done_cnt, busy_at1, led_at1);
      check_output("s0_done_at",  32'(done_at),     32'd2);
      check_output("s0_done_cnt", 32'(done_cnt),    32'd1);
      check_output("s0_n",        32'(bus.n_out),   32'd0);
      check_output("s0_rem",      32'(bus.rem_out), 32'd0);
      check_output("s0_exact",    32'(bus.exact),   32'd1);
      check_output("s0_led",      32'(bus.led_out), 32'h207);

      // S=127: 1..15 = 120, remainder 7
      apply_stimulus(7'd127, 1'b0, 22, done_at, done_cnt, busy_at1, led_at1);
      check_output("s127_done_at",  32'(done_at),     32'd17);
      check_output("s127_done_cnt", 32'(done_cnt),    32'd1);
      check_output("s127_n",        32'(bus.n_out),   32'd15);
      check_output("s127_rem",      32'(bus.rem_out), 32'd7);
      check_output("s127_exact",    32'(bus.exact),   32'd0);
      check_output("s127_led",      32'(bus.led_out), 32'h007);

      // S=11 with target changed to 3 and a second start edge while in CALC
      bus.start  = 1'b0;
      tick();
      bus.target = 7'd11;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      tick();
      bus.target = 7'd3;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      done_at  = -1;
      done_cnt = 0;
      for (int c = 3; c <= 24; c++) begin
         tick();
         if (bus.done === 1'b1) begin
            if (done_at < 0) done_at = c;
            done_cnt++;
         end
      end
      check_output("s11_done_at",  32'(done_at),     32'd6);
      check_output("s11_done_cnt", 32'(done_cnt),    32'd1);
      check_output("s11_n",        32'(bus.n_out),   32'd4);
      check_output("s11_rem",      32'(bus.rem_out), 32'd1);
      check_output("s11_exact",    32'(bus.exact),   32'd0);

      // S=100 aborted by reset while still in CALC
      bus.start  = 1'b0;
      tick();
      bus.target = 7'd100;
      bus.start  = 1'b1;
      tick();
      bus.start  = 1'b0;
      for (int c = 1; c <= 4; c++) tick();
      check_output("s100_busy_mid", 32'(bus.busy),    32'd1);
      check_output("s100_led_mid",  32'(bus.led_out), 32'h003);
      rst = 1'b1;
      #1;
      check_output("rst_mid_n",     32'(bus.n_out),   32'd0);
      check_output("rst_mid_rem",   32'(bus.rem_out), 32'd0);
      check_output("rst_mid_exact", 32'(bus.exact),   32'd0);
      check_output("rst_mid_busy",  32'(bus.busy),    32'd0);
      check_output("rst_mid_done",  32'(bus.done),    32'd0);
      check_output("rst_mid_led",   32'(bus.led_out), 32'h000);
      done_cnt = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (bus.done === 1'b1) done_cnt++;
      end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.done === 1'b1) done_cnt++;
      end
      check_output("rst_no_done",  32'(done_cnt),    32'd0);
      check_output("rst_idle_led", 32'(bus.led_out), 32'h000);

      apply_stimulus(7'd21, 1'b0, 22, done_at, done_cnt, busy_at1, led_at1);
      check_output("s21_done_at", 32'(done_at),     32'd8);
      check_output("s21_n",       32'(bus.n_out),   32'd6);
      check_output("s21_rem",     32'(bus.rem_out), 32'd0);
      check_output("s21_exact",   32'(bus.exact),   32'd1);

      // Sweep every target; odd targets keep start held high through the run
      for (int s = 0; s < 128; s++) begin
         ref_n   = model_n(s);
         ref_rem = s - (ref_n * (ref_n + 1)) / 2;
         apply_stimulus(7'(s), (s % 2) == 1, 22, done_at, done_cnt, busy_at1, led_at1);
         check_output($sformatf("sweep%0d_done_at", s),  32'(done_at),     32'(ref_n + 2));
         check_output($sformatf("sweep%0d_done_cnt", s), 32'(done_cnt),    32'd1);
         check_output($sformatf("sweep%0d_n", s),        32'(bus.n_out),   32'(ref_n));
         check_output($sformatf("sweep%0d_rem", s),      32'(bus.rem_out), 32'(ref_rem));
         check_output($sformatf("sweep%0d_exact", s),    32'(bus.exact),   32'(ref_rem == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
